// File: rtl/img_port_arbiter.sv
// Round-robin arbiter sharing one 64x64 RGB image memory port among NREQ pixel engines.
// Optional macro ARB_PREEMPT_EN enables burst-limited preemption (honouring the owner's lock).
module img_port_arbiter #(
    parameter int NREQ      = 3,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [6*NREQ-1:0]    req_row,
    input  logic [6*NREQ-1:0]    req_col,
    input  logic [NREQ-1:0]      req_we,
    input  logic [24*NREQ-1:0]   req_wpix,
    output logic [NREQ-1:0]      gnt,
    output logic [23:0]          rd_pix,
    output logic [5:0]           mem_row,
    output logic [5:0]           mem_col,
    output logic                 mem_we,
    output logic [23:0]          mem_wpix,
    input  logic [23:0]          mem_rpix,
    output logic                 busy,
    output logic [2:0]           owner
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_nxt;
    logic [NREQ-1:0]   gnt_nxt;
    logic [2:0]        owner_nxt, last_owner, last_nxt;
    logic [NREQ-1:0]   others, cand, rr_oh;
    logic [2:0]        rr_base, rr_idx;
    logic              rr_hit, own_req, own_lock, preempt, cnt_clr;

    logic [NREQ-1:0][5:0]  row_a, col_a;
    logic [NREQ-1:0][23:0] wpix_a;
    logic                  we_sel;

    assign row_a  = req_row;
    assign col_a  = req_col;
    assign wpix_a = req_wpix;

    assign own_req  = |(req & gnt);
    assign own_lock = |(lock & gnt);
    assign others   = req & ~gnt;
    assign busy     = (state == BUSY);
    assign rd_pix   = mem_rpix;

    // On handover the scan starts after the outgoing owner and excludes it.
    assign cand    = (state == BUSY) ? others : req;
    assign rr_base = (state == BUSY) ? owner : last_owner;

    always_comb begin
        int best;
        int d;
        best   = NREQ;
        d      = 0;
        rr_hit = 1'b0;
        rr_idx = '0;
        rr_oh  = '0;
        for (int i = 0; i < NREQ; i++) begin
            d = (i + 2*NREQ - int'(rr_base) - 1) % NREQ;
            if (cand[i] && d < best) begin
                best   = d;
                rr_hit = 1'b1;
                rr_idx = 3'(i);
                rr_oh  = '0;
                rr_oh[i] = 1'b1;
            end
        end
    end

`ifdef ARB_PREEMPT_EN
    logic [7:0] burst_cnt;

    assign preempt = (burst_cnt == 8'(MAX_BURST-1)) && (|others) && !own_lock;

    always_ff @(posedge clk) begin
        if (!rst_n)
            burst_cnt <= '0;
        else if (cnt_clr)
            burst_cnt <= '0;
        else if (state == BUSY && burst_cnt != 8'(MAX_BURST-1))
            burst_cnt <= burst_cnt + 8'd1;
    end
`else
    logic unused_cfg;

    assign preempt    = 1'b0;
    assign unused_cfg = ^{lock, own_lock, cnt_clr, 8'(MAX_BURST)};
`endif

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        owner_nxt = owner;
        last_nxt  = last_owner;
        cnt_clr   = 1'b0;
        if (state == IDLE) begin
            if (rr_hit) begin
                state_nxt = BUSY;
                gnt_nxt   = rr_oh;
                owner_nxt = rr_idx;
                cnt_clr   = 1'b1;
            end
        end else if (!own_req || preempt) begin
            // Release and preempt share one path, so a coincident pair is one handover.
            last_nxt = owner;
            cnt_clr  = 1'b1;
            if (rr_hit) begin
                gnt_nxt   = rr_oh;
                owner_nxt = rr_idx;
            end else begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                owner_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= '0;
            owner      <= '0;
            last_owner <= 3'(NREQ-1);
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            owner      <= owner_nxt;
            last_owner <= last_nxt;
        end
    end

    // Port mux keyed off the registered one-hot grant; zero when idle.
    always_comb begin
        mem_row  = '0;
        mem_col  = '0;
        mem_wpix = '0;
        we_sel   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                mem_row  = row_a[i];
                mem_col  = col_a[i];
                mem_wpix = wpix_a[i];
                we_sel   = req_we[i];
            end
        end
        mem_we = we_sel & busy;
    end

endmodule

// File: tb/tb_img_port_arbiter.sv
// Self-checking bench for img_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural ownership model.
module tb_img_port_arbiter;
    localparam int NREQ = 3;
    localparam int MB   = 16;

    logic                 clk, rst_n;
    logic [NREQ-1:0]      req, lock, we, gnt;
    logic [6*NREQ-1:0]    row, col;
    logic [24*NREQ-1:0]   wpix;
    logic [23:0]          rd_pix, mem_wpix, mem_rpix;
    logic [5:0]           mem_row, mem_col;
    logic                 mem_we, busy;
    logic [2:0]           owner;

    img_port_arbiter #(.NREQ(NREQ), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
        .req_row(row), .req_col(col), .req_we(we), .req_wpix(wpix),
        .gnt(gnt), .rd_pix(rd_pix), .mem_row(mem_row), .mem_col(mem_col),
        .mem_we(mem_we), .mem_wpix(mem_wpix), .mem_rpix(mem_rpix),
        .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: owner index (-1 when idle), who owned last, cycles the owner has held the port.
    int m_own  = -1;
    int m_last = NREQ-1;
    int m_held = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] c, input int base);
        logic [NREQ-1:0] v;
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (base + k) % NREQ;
            v = c >> idx;
            if (v[0]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        logic [NREQ-1:0] one, oth, sh;
        bit rel, pre;
        int w;
        one = 1;
        if (!rst_n) begin
            m_own = -1; m_last = NREQ-1; m_held = 0;
        end else if (m_own < 0) begin
            w = rr_pick(req, m_last);
            if (w >= 0) begin m_own = w; m_held = 1; end
        end else begin
            sh  = req >> m_own;
            rel = !sh[0];
            oth = req & ~(one << m_own);
`ifdef ARB_PREEMPT_EN
            sh  = lock >> m_own;
            pre = (m_held >= MB) && (oth != 0) && !sh[0];
`else
            pre = 1'b0;
`endif
            if (rel || pre) begin
                m_last = m_own;
                w      = rr_pick(oth, m_own);
                m_own  = w;
                m_held = (w >= 0) ? 1 : 0;
            end else begin
                m_held++;
            end
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] one, eg, ws;
        logic [5:0]  er, ec;
        logic [23:0] ep;
        logic        ew;
        if (chk_en) begin
            one = 1; eg = '0; er = '0; ec = '0; ep = '0; ew = 1'b0;
            if (m_own >= 0) begin
                eg = one << m_own;
                er = 6'(row >> (6*m_own));
                ec = 6'(col >> (6*m_own));
                ep = 24'(wpix >> (24*m_own));
                ws = we >> m_own;
                ew = ws[0];
            end
            cmp("gnt",      32'(gnt),      32'(eg));
            cmp("busy",     32'(busy),     32'(m_own >= 0));
            cmp("owner",    32'(owner),    (m_own >= 0) ? 32'(m_own) : 32'd0);
            cmp("mem_row",  32'(mem_row),  32'(er));
            cmp("mem_col",  32'(mem_col),  32'(ec));
            cmp("mem_wpix", 32'(mem_wpix), 32'(ep));
            cmp("mem_we",   32'(mem_we),   32'(ew));
            cmp("rd_pix",   32'(rd_pix),   32'(mem_rpix));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; lock = '0; we = '0;
        row = '0; col = '0; wpix = '0; mem_rpix = 24'h0;
        step(); step();
        chk_en = 1'b1;
        cmp("rst_gnt", 32'(gnt), 32'd0);
        cmp("rst_busy", 32'(busy), 32'd0);
        cmp("rst_owner", 32'(owner), 32'd0);

        // All three request: requester 0 first, one clock latency.
        rst_n = 1'b1; req = 3'b111;
        step();
        cmp("first_grant", 32'(gnt), 32'd1);
        repeat (15) step();
        cmp("burst_hold", 32'(gnt), 32'd1);
        step();
`ifdef ARB_PREEMPT_EN
        cmp("preempt_to1", 32'(gnt), 32'd2);
        repeat (16) step();
        cmp("rr_to2", 32'(gnt), 32'd4);
        repeat (16) step();
        cmp("rr_wrap", 32'(gnt), 32'd1);
`else
        cmp("no_preempt", 32'(gnt), 32'd1);
`endif
        req = '0;
        step();
        cmp("release_idle", 32'(gnt), 32'd0);

        // Lone requester never preempted.
        req = 3'b010;
        repeat (50) step();
        cmp("solo_hold", 32'(gnt), 32'd2);
        req = '0;
        step();
        cmp("solo_rel_gnt", 32'(gnt), 32'd0);
        cmp("solo_rel_busy", 32'(busy), 32'd0);
        cmp("solo_rel_owner", 32'(owner), 32'd0);

        // Locked owner holds through a waiting requester.
        req = 3'b001; lock = 3'b001;
        step();
        cmp("lock_grant", 32'(gnt), 32'd1);
        req = 3'b101;
        repeat (30) step();
        cmp("locked", 32'(gnt), 32'd1);
        lock = '0;
        step();
`ifdef ARB_PREEMPT_EN
        cmp("unlock_preempt", 32'(gnt), 32'd4);
`else
        cmp("unlock_keep", 32'(gnt), 32'd1);
`endif
        req = 3'b100;
        step();
        cmp("owner2", 32'(owner), 32'd2);

        // Datapath: owner 2 writes; requester 0's write is ignored.
        row[17:12] = 6'd5; row[5:0] = 6'd9; col[17:12] = 6'd63;
        wpix[71:48] = 24'h12AB34; we = 3'b101;
        #1;
        cmp("dp_row", 32'(mem_row), 32'd5);
        cmp("dp_col", 32'(mem_col), 32'd63);
        cmp("dp_wpix", 32'(mem_wpix), 32'h12AB34);
        cmp("dp_we", 32'(mem_we), 32'd1);
        we = 3'b001;
        #1;
        cmp("nonowner_we", 32'(mem_we), 32'd0);

        // Reset while owner 1 is writing.
        req = 3'b010; we = 3'b010;
        step();
        cmp("rst_pre_owner", 32'(owner), 32'd1);
        cmp("rst_pre_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        step();
        cmp("rst_mid_gnt", 32'(gnt), 32'd0);
        cmp("rst_mid_we", 32'(mem_we), 32'd0);
        rst_n = 1'b1; req = 3'b111;
        step();
        cmp("post_rst_rr", 32'(gnt), 32'd1);
        req = '0; we = '0;
        step();

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if ($urandom % 24 == 0) req[i] = 1'b0;
                end else if ($urandom % 4 == 0) begin
                    req[i] = 1'b1;
                end
                if ($urandom % 20 == 0) lock[i] = ~lock[i];
            end
            we       = NREQ'($urandom);
            row      = 18'($urandom);
            col      = 18'($urandom);
            wpix     = 72'({$urandom, $urandom, $urandom});
            mem_rpix = 24'($urandom);
            rst_n    = ($urandom % 300 != 0);
            step();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/img_port_arbiter.md
Name: img_port_arbiter

Overview:
- Shares the single 64x64 RGB image memory port (row/col address, read pixel, write enable, write pixel) between NREQ pixel engines: mirror, grayscale and sharpness filter.
- Each engine requests the port. The arbiter grants one owner at a time, round-robin.
- A grant is preempted after MAX_BURST cycles unless the owner asserts lock. Engines use lock for read-modify-write sequences such as the mirror swap.
- Sits between the engines and the image memory. Address and data muxing is combinational from the registered grant.

Parameters:
- NREQ, 3, number of requesters; legal range 2..8.
- MAX_BURST, 16, cycles an unlocked owner may hold the port while another requester waits; legal range 2..255.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  synchronous reset, active low.
- req  in  NREQ  per-requester port request.
- lock  in  NREQ  per-requester no-preempt flag; only the owner's bit is used.
- req_row  in  6*NREQ  packed row address; slice i belongs to requester i.
- req_col  in  6*NREQ  packed column address.
- req_we  in  NREQ  per-requester write enable.
- req_wpix  in  24*NREQ  packed write pixel (R 23:16, G 15:8, B 7:0).
- gnt  out  NREQ  registered one-hot (or zero) grant.
- rd_pix  out  24  mem_rpix broadcast to all requesters.
- mem_row  out  6  image memory row address.
- mem_col  out  6  image memory column address.
- mem_we  out  1  image memory write enable.
- mem_wpix  out  24  image memory write pixel.
- mem_rpix  in  24  image memory read pixel.
- busy  out  1  high while any grant is active.
- owner  out  3  index of current owner; 0 when idle.

Behaviour:
- Reset (rst_n=0 at posedge): gnt=0, state=IDLE, busy=0, owner=0, burst_cnt=0, last_owner=NREQ-1. Requester 0 therefore wins first after reset.
- Reset mid-grant drops gnt on that edge. mem_we is 0 from the following cycle.
- States: IDLE and BUSY.
- IDLE:
  - If req is nonzero, the RR winner is granted at the next edge; go to BUSY, burst_cnt=0.
  - Else stay in IDLE.
  - Grant latency: one clock from req rising to gnt rising.
- RR winner: first set bit of req scanning last_owner+1, last_owner+2, ... modulo NREQ. The current owner's bit is masked on handover.
- BUSY: burst_cnt increments each cycle and saturates at MAX_BURST-1.
- Release: owner drops req. At that edge, gnt moves directly to the RR winner among the remaining requests, with no idle bubble. If none remain, go to IDLE with gnt=0. last_owner=old owner.
- Preempt: all of the following hold at the same edge:
  - burst_cnt==MAX_BURST-1;
  - any other req bit is set;
  - the owner's lock is 0.
  - Result: handover exactly as on release, burst_cnt=0. The preempted requester keeps req high and re-enters RR normally.
- Lock=1: owner is never preempted. burst_cnt stays saturated. Preemption occurs at the first edge where lock=0 and another requester is waiting.
- Simultaneous release and preempt: treated as a single release.
- Owner releasing while no other requests: IDLE for at least one cycle before any re-grant.
- Datapath:
  - mem_row, mem_col, mem_wpix are the owner's slices.
  - mem_we = owner's req_we AND busy.
  - When idle: mem_row=0, mem_col=0, mem_wpix=0, mem_we=0.
  - Non-owner req_we is ignored entirely.
- rd_pix = mem_rpix unconditionally. Requesters sample it only while granted.
- gnt, busy and owner are registered. Mux outputs are combinational from the registered owner; there is no path from req to mem_*.

Optional Feature:
- Macro ARB_PREEMPT_EN.
- Defined: burst counting and preemption as above.
- Undefined: no burst_cnt logic and lock is ignored. The owner keeps the grant until it drops req; handover on release is unchanged. MAX_BURST has no effect.

Test Plan:
- Reset then req=3'b111, no lock, each owner holds req 40 cycles (preempt on) -> gnt sequence 001,010,100,001,... Each grant lasts exactly 16 cycles. First gnt one clock after req.
- Only req[1]=1 held 50 cycles -> gnt=010 continuously, no preemption. Drop req[1] -> next edge gnt=0, busy=0, owner=0.
- Owner 0 with lock[0]=1 for 30 cycles while req[2]=1 -> no handover during lock. Lock drops at cycle 30 -> gnt=100 at next edge.
- Owner 2 writes row=5, col=63, wpix=24'h12AB34, req_we=1, while requester 0 drives req_we=1 and row=9 -> mem_row=5, mem_col=63, mem_wpix=24'h12AB34, mem_we=1. Requester 0's write never reaches memory.
- rst_n=0 for one cycle while owner 1 is writing -> next cycle gnt=0, mem_we=0. After release, requester 0 wins over simultaneous req 1 and 2.
- ARB_PREEMPT_EN undefined, req=3'b011 with owner 0 holding 100 cycles -> no handover until req[0] drops, then gnt=010 at next edge.
